// File: rtl/am_mod_pipe.sv
// am_mod_pipe: three-stage AM / DSB-SC modulator with passthrough modes,
// output saturation and a sticky clip flag. Offset-binary samples in and out.
module am_mod_pipe #(
  parameter int unsigned DW = 16,
  parameter int unsigned MW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] carrier,
  input  logic [DW-1:0] modulated,
  input  logic [MW:0]   ma,
  input  logic [1:0]    mode,
  input  logic          clip_clr,
  output logic          out_valid,
  output logic [DW-1:0] am_sig,
  output logic          clip_flag
);

  localparam int unsigned MAW     = MW + 1;        // depth width
  localparam int unsigned EW      = DW + 1;        // envelope width
  localparam int unsigned PW      = DW + MW + 2;   // depth product width
  localparam int unsigned AW      = EW + DW;       // stage-3 product width
  localparam int unsigned HALF_M1 = (2 ** (DW - 1)) - 1;

  localparam logic [MAW-1:0]       MA_FULL  = MAW'(2 ** MW);
  localparam logic [DW-1:0]        MIDSCALE = DW'(2 ** (DW - 1));
  localparam logic signed [AW-1:0] SAT_MAX  = AW'(HALF_M1);
  localparam logic signed [AW-1:0] SAT_MIN  = ~SAT_MAX;

  localparam logic [1:0] MODE_AM     = 2'd0;
  localparam logic [1:0] MODE_DSB    = 2'd1;
  localparam logic [1:0] MODE_PASS_C = 2'd2;
  localparam logic [1:0] MODE_PASS_M = 2'd3;

  // Stage 1 registers
  logic                  v1_q,     v1_d;
  logic signed [DW-1:0]  s_c1_q,   s_c1_d;
  logic signed [DW-1:0]  s_m1_q,   s_m1_d;
  logic [MAW-1:0]        ma1_q,    ma1_d;
  logic [1:0]            mode1_q,  mode1_d;

  // Stage 2 registers
  logic                  v2_q,     v2_d;
  logic signed [DW-1:0]  s_c2_q,   s_c2_d;
  logic signed [DW-1:0]  s_m2_q,   s_m2_d;
  logic signed [EW-1:0]  env2_q,   env2_d;
  logic [1:0]            mode2_q,  mode2_d;

  // Output registers
  logic                  out_valid_q, out_valid_d;
  logic [DW-1:0]         am_sig_q,    am_sig_d;
  logic                  clip_q,      clip_d;

  // Stage-2 and stage-3 intermediates
  logic signed [PW-1:0]  m_prod;
  logic signed [DW-1:0]  m_sc;
  logic signed [AW-1:0]  am_prod;
  logic signed [AW-1:0]  dsb_prod;
  logic signed [AW-1:0]  r_wide;
  logic signed [DW-1:0]  r_sat;
  logic                  sat;

  // Stage 1: convert to two's complement, clamp depth, capture mode
  always_comb begin
    v1_d    = in_valid;
    s_c1_d  = s_c1_q;
    s_m1_d  = s_m1_q;
    ma1_d   = ma1_q;
    mode1_d = mode1_q;
    if (in_valid) begin
      s_c1_d  = {~carrier[DW-1], carrier[DW-2:0]};
      s_m1_d  = {~modulated[DW-1], modulated[DW-2:0]};
      ma1_d   = (ma > MA_FULL) ? MA_FULL : ma;
      mode1_d = mode;
    end
  end

  // Stage 2: scale the modulating wave by depth and bias into the envelope
  always_comb begin
    m_prod  = $signed({{(PW-DW){s_m1_q[DW-1]}}, s_m1_q})
            * $signed({{(PW-MAW){1'b0}}, ma1_q});
    m_sc    = DW'(m_prod >>> MW);
    v2_d    = v1_q;
    s_c2_d  = s_c2_q;
    s_m2_d  = s_m2_q;
    env2_d  = env2_q;
    mode2_d = mode2_q;
    if (v1_q) begin
      s_c2_d  = s_c1_q;
      s_m2_d  = s_m1_q;
      env2_d  = $signed(EW'(HALF_M1)) + $signed({m_sc[DW-1], m_sc});
      mode2_d = mode1_q;
    end
  end

  // Stage 3: mode select, saturation, offset-binary output and clip tracking
  always_comb begin
    am_prod  = $signed({{DW{env2_q[EW-1]}}, env2_q})
             * $signed({{EW{s_c2_q[DW-1]}}, s_c2_q});
    dsb_prod = $signed({{EW{s_m2_q[DW-1]}}, s_m2_q})
             * $signed({{EW{s_c2_q[DW-1]}}, s_c2_q});
    r_wide   = am_prod >>> DW;
    case (mode2_q)
      MODE_AM:     r_wide = am_prod >>> DW;
      MODE_DSB:    r_wide = dsb_prod >>> (DW - 1);
      MODE_PASS_C: r_wide = $signed({{EW{s_c2_q[DW-1]}}, s_c2_q});
      MODE_PASS_M: r_wide = $signed({{EW{s_m2_q[DW-1]}}, s_m2_q});
      default:     r_wide = am_prod >>> DW;
    endcase

    sat   = 1'b0;
    r_sat = DW'(r_wide);
    if (r_wide > SAT_MAX) begin
      sat   = 1'b1;
      r_sat = DW'(SAT_MAX);
    end else if (r_wide < SAT_MIN) begin
      sat   = 1'b1;
      r_sat = DW'(SAT_MIN);
    end

    out_valid_d = v2_q;
    am_sig_d    = am_sig_q;
    if (v2_q) begin
      am_sig_d = {~r_sat[DW-1], r_sat[DW-2:0]};
    end
    // a new clip on the same cycle as a clear keeps the flag set
    clip_d = (v2_q & sat) | (clip_q & ~clip_clr);
  end

  // Pipeline state; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      s_c1_q      <= '0;
      s_m1_q      <= '0;
      ma1_q       <= '0;
      mode1_q     <= '0;
      v2_q        <= 1'b0;
      s_c2_q      <= '0;
      s_m2_q      <= '0;
      env2_q      <= '0;
      mode2_q     <= '0;
      out_valid_q <= 1'b0;
      am_sig_q    <= MIDSCALE;
      clip_q      <= 1'b0;
    end else begin
      v1_q        <= v1_d;
      s_c1_q      <= s_c1_d;
      s_m1_q      <= s_m1_d;
      ma1_q       <= ma1_d;
      mode1_q     <= mode1_d;
      v2_q        <= v2_d;
      s_c2_q      <= s_c2_d;
      s_m2_q      <= s_m2_d;
      env2_q      <= env2_d;
      mode2_q     <= mode2_d;
      out_valid_q <= out_valid_d;
      am_sig_q    <= am_sig_d;
      clip_q      <= clip_d;
    end
  end

  assign out_valid = out_valid_q;
  assign am_sig    = am_sig_q;
  assign clip_flag = clip_q;

endmodule

// File: tb/tb_am_mod_pipe.sv
// tb_am_mod_pipe: directed bench for am_mod_pipe with an arithmetic reference
// model, a per-cycle compare process and hand-computed literal checks.
module tb_am_mod_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] carrier = 16'h0;
  logic [15:0] modulated = 16'h0;
  logic [8:0]  ma = 9'h0;
  logic [1:0]  mode = 2'd0;
  logic        clip_clr = 1'b0;
  logic        out_valid;
  logic [15:0] am_sig;
  logic        clip_flag;

  int errors = 0;
  int checks = 0;

  am_mod_pipe #(.DW(16), .MW(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .carrier(carrier),
    .modulated(modulated), .ma(ma), .mode(mode), .clip_clr(clip_clr),
    .out_valid(out_valid), .am_sig(am_sig), .clip_flag(clip_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: result and saturation for one sample
  function automatic void model(input logic [15:0] c, input logic [15:0] m,
                                input int mdepth, input int md,
                                output logic [15:0] res, output bit sat);
    int     sc, sm, mac, msc, env;
    longint r;
    sc  = int'(c) - 32768;
    sm  = int'(m) - 32768;
    mac = (mdepth > 256) ? 256 : mdepth;
    case (md)
      0: begin
        msc = (sm * mac) >>> 8;
        env = 32767 + msc;
        r   = (longint'(env) * longint'(sc)) >>> 16;
      end
      1:       r = longint'(sm * sc) >>> 15;
      2:       r = longint'(sc);
      default: r = longint'(sm);
    endcase
    sat = (r > 32767) || (r < -32768);
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    res = 16'(r + 32768);
  endfunction

  typedef struct { int due; logic [15:0] val; bit sat; } exp_t;
  exp_t        sb[$];
  int          cyc = 0;
  logic        m_valid = 1'b0;
  logic [15:0] m_am = 16'h8000;
  logic        m_clip = 1'b0;

  // Scoreboard: each strobed sample is due two edges after it is captured
  always @(posedge clk or negedge rst_n) begin
    int          now;
    exp_t        e;
    logic [15:0] rv;
    bit          rs;
    if (!rst_n) begin
      sb.delete();
      m_valid <= 1'b0;
      m_am    <= 16'h8000;
      m_clip  <= 1'b0;
    end else begin
      now = cyc + 1;
      cyc <= now;
      if (sb.size() > 0 && sb[0].due == now) begin
        e = sb.pop_front();
        m_valid <= 1'b1;
        m_am    <= e.val;
        m_clip  <= e.sat | (m_clip & ~clip_clr);
      end else begin
        m_valid <= 1'b0;
        m_clip  <= m_clip & ~clip_clr;
      end
      if (in_valid) begin
        model(carrier, modulated, int'(ma), int'(mode), rv, rs);
        sb.push_back('{due: now + 2, val: rv, sat: rs});
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk) begin
    chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
    chk("cyc_am_sig", 32'(am_sig), 32'(m_am));
    chk("cyc_clip_flag", 32'(clip_flag), 32'(m_clip));
  end

  logic        rec_en = 1'b0;
  bit          rec_v[$];
  logic [15:0] rec_d[$];
  always @(negedge clk) begin
    if (rec_en) begin
      rec_v.push_back(out_valid);
      rec_d.push_back(am_sig);
    end
  end

  task automatic send(input logic [15:0] c, input logic [15:0] m,
                      input logic [8:0] d, input logic [1:0] md);
    @(posedge clk); #1;
    in_valid = 1'b1; carrier = c; modulated = m; ma = d; mode = md;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  logic [15:0] tv_c[8] = '{16'h0000, 16'h4000, 16'hC000, 16'h7FFF,
                           16'h8001, 16'hFFFF, 16'h1234, 16'hE000};
  logic [15:0] tv_m[8] = '{16'hFFFF, 16'h0000, 16'h8000, 16'h3000,
                           16'hC123, 16'h0001, 16'hFFFF, 16'h2222};
  logic [8:0]  tv_a[8] = '{9'd256, 9'd128, 9'd64, 9'd300,
                           9'd1, 9'd200, 9'd256, 9'd511};
  logic [1:0]  tv_o[8] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd1};

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_am_sig", 32'(am_sig), 32'h8000);
    chk("rst_clip", 32'(clip_flag), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // AM at 100% depth
    send(16'hFFFF, 16'hFFFF, 9'd256, 2'd0);
    idle(3);
    chk("am100_valid", 32'(out_valid), 32'h1);
    chk("am100_sig", 32'(am_sig), 32'hFFFE);
    chk("am100_clip", 32'(clip_flag), 32'h0);

    // AM with zero depth
    send(16'hFFFF, 16'h1234, 9'd0, 2'd0);
    idle(3);
    chk("am0_sig", 32'(am_sig), 32'hBFFF);

    // Depth above full scale clamps to 100%
    send(16'hFFFF, 16'hFFFF, 9'd511, 2'd0);
    idle(3);
    chk("clamp_sig", 32'(am_sig), 32'hFFFE);

    // DSB-SC clip and sticky flag
    send(16'h0000, 16'h0000, 9'd0, 2'd1);
    idle(3);
    chk("dsb_sig", 32'(am_sig), 32'hFFFF);
    chk("dsb_clip_rise", 32'(clip_flag), 32'h1);
    idle(3);
    chk("dsb_clip_sticky", 32'(clip_flag), 32'h1);
    @(posedge clk); #1; clip_clr = 1'b1;
    @(posedge clk); #1; clip_clr = 1'b0;
    chk("clip_cleared", 32'(clip_flag), 32'h0);

    // Clear coinciding with a fresh clip leaves the flag set
    send(16'h0000, 16'h0000, 9'd0, 2'd1);
    idle(2);
    clip_clr = 1'b1;
    idle(1);
    clip_clr = 1'b0;
    chk("clip_set_wins", 32'(clip_flag), 32'h1);
    @(posedge clk); #1; clip_clr = 1'b1;
    @(posedge clk); #1; clip_clr = 1'b0;

    // Passthrough modes on consecutive samples
    send(16'h1234, 16'hABCD, 9'd0, 2'd2);
    send(16'h5555, 16'h9876, 9'd0, 2'd3);
    idle(2);
    chk("pass_carrier", 32'(am_sig), 32'h1234);
    idle(1);
    chk("pass_modulated", 32'(am_sig), 32'h9876);
    idle(3);

    // Back-to-back vectors with per-sample depth and mode changes
    for (int i = 0; i < 8; i++) send(tv_c[i], tv_m[i], tv_a[i], tv_o[i]);
    idle(5);
    @(posedge clk); #1; clip_clr = 1'b1;
    @(posedge clk); #1; clip_clr = 1'b0;

    // Throughput: ramp of ten, two-cycle gap, one more sample
    for (int i = 0; i < 10; i++) begin
      send(16'h8000 + 16'(i), 16'h0000, 9'd0, 2'd2);
      if (i == 0) rec_en = 1'b1;
    end
    idle(2);
    send(16'h8055, 16'h0000, 9'd0, 2'd2);
    idle(6);
    rec_en = 1'b0;
    chk("tp_len", 32'(rec_v.size()), 32'd18);
    if (rec_v.size() == 18) begin
      for (int i = 0; i < 18; i++) begin
        chk("tp_valid", 32'(rec_v[i]), 32'((i >= 3 && i <= 12) || i == 15));
        if (i >= 3 && i <= 12)      chk("tp_ramp", 32'(rec_d[i]), 32'h8000 + 32'(i - 3));
        else if (i == 13 || i == 14) chk("tp_hold", 32'(rec_d[i]), 32'h8009);
        else if (i >= 15)           chk("tp_last", 32'(rec_d[i]), 32'h8055);
      end
    end

    // Reset mid-stream with samples in flight
    send(16'h0000, 16'h0000, 9'd0, 2'd1);
    send(16'h1111, 16'h0000, 9'd0, 2'd2);
    send(16'h2222, 16'h0000, 9'd0, 2'd2);
    idle(1);
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_sig", 32'(am_sig), 32'h8000);
    chk("midrst_clip", 32'(clip_flag), 32'h0);
    idle(2);
    @(posedge clk); #2 rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      chk("post_rst_quiet", 32'(out_valid), 32'h0);
    end
    send(16'h8123, 16'h0000, 9'd0, 2'd2);
    idle(2);
    chk("post_rst_early", 32'(out_valid), 32'h0);
    idle(1);
    chk("post_rst_valid", 32'(out_valid), 32'h1);
    chk("post_rst_sig", 32'(am_sig), 32'h8123);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
